// File: rtl/collaudo_pkg.sv
// Shared types and helpers for the collaudo_porta NAND self-test sequencer.
package collaudo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINE   = 2'd3
    } stato_t;

    localparam int N_VETTORI = 4;

    function automatic logic atteso_nand(input logic x, input logic y);
        return ~(x & y);
    endfunction

endpackage

// File: rtl/collaudo_porta_contatore_attesa.sv
// Loadable down-counter that times the settle interval; zero_o flags expiry.
module contatore_attesa #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load takes priority; decrement holds at zero instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/collaudo_porta.sv
// NAND self-test sequencer: applies all four {y,x} vectors, checks z, counts mismatches.
// Optional first-failure log enabled by defining COLLAUDO_ERRLOG_EN.
module collaudo_porta
    import collaudo_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int ERRW   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            x_o,
    output logic            y_o,
    input  logic            z_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [ERRW-1:0] err_cnt_o,
`ifdef COLLAUDO_ERRLOG_EN
    output logic [1:0]      first_fail_o,
    output logic            first_fail_vld_o,
`endif
    output logic            pass_o
);

    localparam int              CW       = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0]   RICARICA = CW'(SETTLE - 1);
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    if (SETTLE < 1) begin : g_settle_illegal
        $error("collaudo_porta: SETTLE must be at least 1");
    end

    stato_t          stato_q;
    logic [1:0]      idx_q;
    logic [1:0]      idx_d;
    logic            x_q, y_q, busy_q, done_q, pass_q;
    logic [ERRW-1:0] err_q;
    logic [ERRW-1:0] err_d;

    logic start_ok_s, errore_s, ultimo_s, zero_s, cnt_load_s, cnt_dec_s;

    assign start_ok_s = start_i && ((stato_q == ST_IDLE) || (stato_q == ST_FINE));
    assign ultimo_s   = (idx_q == 2'(N_VETTORI - 1));
    assign errore_s   = (stato_q == ST_CHECK) && (z_i != atteso_nand(idx_q[0], idx_q[1]));
    assign idx_d      = idx_q + 2'd1;

    // Next mismatch count, saturating at all-ones.
    always_comb begin
        err_d = err_q;
        if (errore_s && (err_q != ERR_MAX)) begin
            err_d = err_q + ERRW'(1);
        end else begin
            err_d = err_q;
        end
    end

    // Settle timer is reloaded on every new vector and counts down only while settling.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        if (start_ok_s || ((stato_q == ST_CHECK) && !ultimo_s)) begin
            cnt_load_s = 1'b1;
        end else begin
            cnt_load_s = 1'b0;
        end
        cnt_dec_s = (stato_q == ST_SETTLE);
    end

    contatore_attesa #(.W(CW)) u_attesa (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (cnt_load_s),
        .val_i  (RICARICA),
        .dec_i  (cnt_dec_s),
        .zero_o (zero_s)
    );

    // Sequencer FSM with registered vector drive and result outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stato_q <= ST_IDLE;
            idx_q   <= 2'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            case (stato_q)
                ST_IDLE, ST_FINE: begin
                    if (start_i) begin
                        stato_q <= ST_SETTLE;
                        idx_q   <= 2'd0;
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (zero_s) begin
                        stato_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_q <= err_d;
                    if (ultimo_s) begin
                        stato_q <= ST_FINE;
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        stato_q <= ST_SETTLE;
                        idx_q   <= idx_d;
                        x_q     <= idx_d[0];
                        y_q     <= idx_d[1];
                    end
                end
                default: begin
                    stato_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;

`ifdef COLLAUDO_ERRLOG_EN
    logic [1:0] ff_q;
    logic       ffv_q;

    // Keep only the first failing {y,x} of a pass.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q  <= 2'b00;
            ffv_q <= 1'b0;
        end else if (start_ok_s) begin
            ff_q  <= 2'b00;
            ffv_q <= 1'b0;
        end else if (errore_s && !ffv_q) begin
            ff_q  <= idx_q;
            ffv_q <= 1'b1;
        end
    end

    assign first_fail_o     = ff_q;
    assign first_fail_vld_o = ffv_q;
`endif

endmodule

// File: tb/tb_collaudo_porta.sv
// Randomized self-checking bench: two sequencers (default and SETTLE=1/ERRW=1) against a truth-table gate.
module tb_collaudo_porta;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [3:0] tt;
    logic       x_a, y_a, z_a, busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic       x_b, y_b, z_b, busy_b, done_b, pass_b;
    logic [0:0] err_b;
    logic [1:0] ff_a, ff_b;
    logic       ffv_a, ffv_b;
    logic [1:0] dly_a0, dly_a1, dly_b;
    int         n_checks = 0;
    int         n_fail   = 0;

    collaudo_porta #(.SETTLE(2), .ERRW(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .x_o(x_a), .y_o(y_a), .z_i(z_a),
        .busy_o(busy_a), .done_o(done_a), .err_cnt_o(err_a),
`ifdef COLLAUDO_ERRLOG_EN
        .first_fail_o(ff_a), .first_fail_vld_o(ffv_a),
`endif
        .pass_o(pass_a)
    );

    collaudo_porta #(.SETTLE(1), .ERRW(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .x_o(x_b), .y_o(y_b), .z_i(z_b),
        .busy_o(busy_b), .done_o(done_b), .err_cnt_o(err_b),
`ifdef COLLAUDO_ERRLOG_EN
        .first_fail_o(ff_b), .first_fail_vld_o(ffv_b),
`endif
        .pass_o(pass_b)
    );

`ifndef COLLAUDO_ERRLOG_EN
    assign ff_a = 2'b00; assign ffv_a = 1'b0;
    assign ff_b = 2'b00; assign ffv_b = 1'b0;
`endif

    // Gate under test: arbitrary truth table, output lags its inputs by exactly SETTLE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_a0 <= 2'b00; dly_a1 <= 2'b00; dly_b <= 2'b00;
        end else begin
            dly_a0 <= {y_a, x_a}; dly_a1 <= dly_a0; dly_b <= {y_b, x_b};
        end
    end
    assign z_a = tt[dly_a1];
    assign z_b = tt[dly_b];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: mismatches of table t against NAND over all four {y,x}, saturated to w bits.
    function automatic int exp_err(input logic [3:0] t, input int w);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (t[i] != !((i % 2 == 1) && (i >= 2))) n++;
        end
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    endfunction

    function automatic int exp_first(input logic [3:0] t);
        for (int i = 0; i < 4; i++) begin
            if (t[i] != !((i % 2 == 1) && (i >= 2))) return i;
        end
        return -1;
    endfunction

    task automatic check_dut(input string nm, input int s, input int w, input int k,
                             input logic xo, input logic yo, input logic bo, input logic dn,
                             input logic ps, input logic [3:0] er, input logic [1:0] ff, input logic fv);
        int per = s + 1;
        int e   = exp_err(tt, w);
        int f   = exp_first(tt);
        if (k < 4 * per) begin
            chk({nm, "_vec"},  32'({yo, xo}), 32'(k / per));
            chk({nm, "_busy"}, 32'(bo), 32'd1);
            chk({nm, "_done"}, 32'(dn), 32'd0);
            chk({nm, "_pass"}, 32'(ps), 32'd0);
            if (k == 0) begin
                chk({nm, "_err_clr"}, 32'(er), 32'd0);
`ifdef COLLAUDO_ERRLOG_EN
                chk({nm, "_ffv_clr"}, 32'(fv), 32'd0);
                chk({nm, "_ff_clr"},  32'(ff), 32'd0);
`endif
            end
        end else begin
            chk({nm, "_vec_fine"}, 32'({yo, xo}), 32'd0);
            chk({nm, "_busy"}, 32'(bo), 32'd0);
            chk({nm, "_done"}, 32'(dn), 32'd1);
            chk({nm, "_pass"}, 32'(ps), 32'(e == 0));
            chk({nm, "_err"},  32'(er), 32'(e));
`ifdef COLLAUDO_ERRLOG_EN
            chk({nm, "_ffv"}, 32'(fv), 32'(f >= 0));
            chk({nm, "_ff"},  32'(ff), 32'((f >= 0) ? f : 0));
`endif
        end
    endtask

    task automatic check_cycle(input int k);
        check_dut("a", 2, 4, k, x_a, y_a, busy_a, done_a, pass_a, err_a, ff_a, ffv_a);
        check_dut("b", 1, 1, k, x_b, y_b, busy_b, done_b, pass_b, {3'b000, err_b}, ff_b, ffv_b);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_a_xy"},   32'({y_a, x_a}), 32'd0);
        chk({tag, "_a_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_a_done"}, 32'(done_a), 32'd0);
        chk({tag, "_a_pass"}, 32'(pass_a), 32'd0);
        chk({tag, "_a_err"},  32'(err_a),  32'd0);
        chk({tag, "_b_xy"},   32'({y_b, x_b}), 32'd0);
        chk({tag, "_b_busy"}, 32'(busy_b), 32'd0);
        chk({tag, "_b_done"}, 32'(done_b), 32'd0);
        chk({tag, "_b_err"},  32'(err_b),  32'd0);
`ifdef COLLAUDO_ERRLOG_EN
        chk({tag, "_a_ffv"}, 32'(ffv_a), 32'd0);
        chk({tag, "_a_ff"},  32'(ff_a),  32'd0);
`endif
    endtask

    // One full pass; 'again' re-pulses start so it is sampled at edge E0+again+1.
    task automatic run_pass(input logic [3:0] t, input int again);
        tt = t;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            check_cycle(k);
            start = (k == again);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic reset_test();
        tt = 4'b0000;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_err_a", 32'(err_a), 32'd1);
        #2; rst = 1'b1;
        #1; check_quiet("rst_async");
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_quiet("post_rst_idle");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tt = 4'b0111;
        repeat (2) @(posedge clk);
        #1; check_quiet("por");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1; check_quiet("idle");
        run_pass(4'b0111, -1);
        run_pass(4'b1111, -1);
        run_pass(4'b0000, 6);
        run_pass(4'b0111, -1);
        for (int r = 0; r < 6; r++) begin
            run_pass(4'($urandom), -1);
        end
        reset_test();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
